// File: rtl/disparity_pkg.sv
// Shared constants and buffer-entry type for the disparity winner-take-all stage.
package disparity_pkg;
  localparam int LINE_PIXELS = 640;
  localparam int DISP_W      = 6;
  localparam int PIX_W       = 10;
  localparam int NUM_CAND    = 4;
  localparam int DEF_SAD_W   = 16;

  // Entry at the default SAD width; the top rebuilds the same shape for its SAD_W.
  typedef struct packed {
    logic [DEF_SAD_W-1:0] sad;
    logic [DISP_W-1:0]    disparity;
  } best_entry_t;
endpackage

// File: rtl/disparity_wta_sad_min4.sv
// Combinational 4-way minimum over (sad, disparity) pairs; on equal SAD the lower index wins.
module sad_min4
  import disparity_pkg::*;
#(
  parameter int SAD_W = 16
) (
  input  logic [SAD_W-1:0]  sad1_i,
  input  logic [SAD_W-1:0]  sad2_i,
  input  logic [SAD_W-1:0]  sad3_i,
  input  logic [SAD_W-1:0]  sad4_i,
  input  logic [DISP_W-1:0] disp1_i,
  input  logic [DISP_W-1:0] disp2_i,
  input  logic [DISP_W-1:0] disp3_i,
  input  logic [DISP_W-1:0] disp4_i,
  output logic [SAD_W-1:0]  min_sad_o,
  output logic [DISP_W-1:0] min_disp_o
);
  logic [SAD_W-1:0]  sad_a, sad_b;
  logic [DISP_W-1:0] disp_a, disp_b;

  // Strict compares everywhere: the left (lower-index) operand survives ties.
  always_comb begin
    sad_a  = sad1_i;
    disp_a = disp1_i;
    if (sad2_i < sad1_i) begin
      sad_a  = sad2_i;
      disp_a = disp2_i;
    end
    sad_b  = sad3_i;
    disp_b = disp3_i;
    if (sad4_i < sad3_i) begin
      sad_b  = sad4_i;
      disp_b = disp4_i;
    end
    min_sad_o  = sad_a;
    min_disp_o = disp_a;
    if (sad_b < sad_a) begin
      min_sad_o  = sad_b;
      min_disp_o = disp_b;
    end
  end
endmodule

// File: rtl/disparity_wta.sv
// Per-pixel minimum-SAD tracker for one scanline with in-order depth readout.
// Optional DISPARITY_WTA_THRESH_EN forces out_disparity to 0 when the winning SAD exceeds SAD_THRESH.
module disparity_wta
  import disparity_pkg::*;
#(
  parameter int               SAD_W      = 16,
  parameter logic [SAD_W-1:0] SAD_THRESH = {SAD_W{1'b1}}
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              valid,
  input  logic [PIX_W-1:0]  pixel,
  input  logic [DISP_W-1:0] disparity_1,
  input  logic [DISP_W-1:0] disparity_2,
  input  logic [DISP_W-1:0] disparity_3,
  input  logic [DISP_W-1:0] disparity_4,
  input  logic [SAD_W-1:0]  sad_1,
  input  logic [SAD_W-1:0]  sad_2,
  input  logic [SAD_W-1:0]  sad_3,
  input  logic [SAD_W-1:0]  sad_4,
  input  logic              clear_buffer,
  output logic              out_valid,
  output logic [PIX_W-1:0]  out_pixel,
  output logic [DISP_W-1:0] out_disparity,
  output logic [SAD_W-1:0]  out_sad
);
  typedef struct packed {
    logic [SAD_W-1:0]  sad;
    logic [DISP_W-1:0] disparity;
  } entry_t;

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(LINE_PIXELS - 1);

  logic [SAD_W-1:0]  min_sad;
  logic [DISP_W-1:0] min_disp;
  logic              take;

  logic              s1_valid_q, s1_first_q;
  logic [PIX_W-1:0]  s1_pixel_q;
  logic [SAD_W-1:0]  s1_sad_q;
  logic [DISP_W-1:0] s1_disp_q;

  entry_t            best_q [LINE_PIXELS];
  entry_t            cur_entry, rd_entry;
  logic              wr_en;

  logic [PIX_W-1:0]  rd_addr_q, rd_addr_d;
  logic [DISP_W-1:0] rd_disp;

  logic              out_valid_q;
  logic [PIX_W-1:0]  out_pixel_q;
  logic [DISP_W-1:0] out_disp_q;
  logic [SAD_W-1:0]  out_sad_q;

  sad_min4 #(.SAD_W(SAD_W)) u_min (
    .sad1_i    (sad_1),
    .sad2_i    (sad_2),
    .sad3_i    (sad_3),
    .sad4_i    (sad_4),
    .disp1_i   (disparity_1),
    .disp2_i   (disparity_2),
    .disp3_i   (disparity_3),
    .disp4_i   (disparity_4),
    .min_sad_o (min_sad),
    .min_disp_o(min_disp)
  );

  // Readout owns the cycle; blank columns past the line end never reach the buffer.
  assign take = valid && !clear_buffer && (pixel <= LAST_PIX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_pixel_q <= '0;
      s1_sad_q   <= '0;
      s1_disp_q  <= '0;
    end else begin
      s1_valid_q <= take;
      s1_first_q <= (disparity_1 == '0);
      s1_pixel_q <= pixel;
      s1_sad_q   <= min_sad;
      s1_disp_q  <= min_disp;
    end
  end

  assign cur_entry = best_q[s1_pixel_q];
  assign wr_en     = s1_valid_q && (s1_first_q || (s1_sad_q < cur_entry.sad));

  always_ff @(posedge clock) begin
    if (wr_en) begin
      best_q[s1_pixel_q] <= '{sad: s1_sad_q, disparity: s1_disp_q};
    end
  end

  always_comb begin
    rd_addr_d = '0;
    if (clear_buffer) begin
      rd_addr_d = (rd_addr_q == LAST_PIX) ? rd_addr_q : rd_addr_q + 1'b1;
    end
  end

  assign rd_entry = best_q[rd_addr_q];

`ifdef DISPARITY_WTA_THRESH_EN
  assign rd_disp = (rd_entry.sad > SAD_THRESH) ? '0 : rd_entry.disparity;
`else
  logic [SAD_W-1:0] unused_thresh;
  assign unused_thresh = SAD_THRESH;
  assign rd_disp       = rd_entry.disparity;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_disp_q  <= '0;
      out_sad_q   <= '0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= clear_buffer;
      if (clear_buffer) begin
        out_pixel_q <= rd_addr_q;
        out_disp_q  <= rd_disp;
        out_sad_q   <= rd_entry.sad;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pixel     = out_pixel_q;
  assign out_disparity = out_disp_q;
  assign out_sad       = out_sad_q;
endmodule

// File: tb/tb_disparity_wta.sv
// Directed bench for disparity_wta: pass updates, tie rules, dropped cycles, async reset, readout.
module tb_disparity_wta;
  import disparity_pkg::*;

  localparam int SAD_W = 16;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              valid = 1'b0;
  logic [PIX_W-1:0]  pixel = '0;
  logic [DISP_W-1:0] disparity_1 = '0, disparity_2 = '0, disparity_3 = '0, disparity_4 = '0;
  logic [SAD_W-1:0]  sad_1 = '0, sad_2 = '0, sad_3 = '0, sad_4 = '0;
  logic              clear_buffer = 1'b0;
  logic              out_valid;
  logic [PIX_W-1:0]  out_pixel;
  logic [DISP_W-1:0] out_disparity;
  logic [SAD_W-1:0]  out_sad;

  int n_cmp = 0;
  int n_err = 0;
  int exp_sad  [LINE_PIXELS];
  int exp_disp [LINE_PIXELS];

  disparity_wta #(.SAD_W(SAD_W), .SAD_THRESH(16'd50)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .valid        (valid),
    .pixel        (pixel),
    .disparity_1  (disparity_1),
    .disparity_2  (disparity_2),
    .disparity_3  (disparity_3),
    .disparity_4  (disparity_4),
    .sad_1        (sad_1),
    .sad_2        (sad_2),
    .sad_3        (sad_3),
    .sad_4        (sad_4),
    .clear_buffer (clear_buffer),
    .out_valid    (out_valid),
    .out_pixel    (out_pixel),
    .out_disparity(out_disparity),
    .out_sad      (out_sad)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int exp_out_disp(input int p);
`ifdef DISPARITY_WTA_THRESH_EN
    return (exp_sad[p] > 50) ? 0 : exp_disp[p];
`else
    return exp_disp[p];
`endif
  endfunction

  function automatic int sadf(input int pix, input int d);
    return ((pix * 37 + d * 91 + ((pix ^ d) & 31) * 5) % 200) + 1;
  endfunction

  task automatic send(input bit v, input int pix, input int d0,
                      input int s1, input int s2, input int s3, input int s4);
    valid       = v;
    pixel       = PIX_W'(pix);
    disparity_1 = DISP_W'(d0);
    disparity_2 = DISP_W'(d0 + 1);
    disparity_3 = DISP_W'(d0 + 2);
    disparity_4 = DISP_W'(d0 + 3);
    sad_1       = SAD_W'(s1);
    sad_2       = SAD_W'(s2);
    sad_3       = SAD_W'(s3);
    sad_4       = SAD_W'(s4);
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  // Holds clear_buffer for exactly 640 edges; optionally fires a colliding write mid-readout.
  task automatic readout(input bit collide);
    clear_buffer = 1'b1;
    for (int k = 0; k < LINE_PIXELS; k++) begin
      @(posedge clock); #1;
      if (k == LINE_PIXELS - 1) clear_buffer = 1'b0;
      if (collide && k == 100) begin
        valid       = 1'b1;
        pixel       = PIX_W'(600);
        disparity_1 = '0; disparity_2 = 6'd1; disparity_3 = 6'd2; disparity_4 = 6'd3;
        sad_1 = 16'd1; sad_2 = 16'd1; sad_3 = 16'd1; sad_4 = 16'd1;
      end
      if (k == 101) valid = 1'b0;
      check($sformatf("rd_vld[%0d]", k), 32'(out_valid), 32'd1);
      check($sformatf("rd_pix[%0d]", k), 32'(out_pixel), 32'(k));
      check($sformatf("rd_disp[%0d]", k), 32'(out_disparity), 32'(exp_out_disp(k)));
      check($sformatf("rd_sad[%0d]", k), 32'(out_sad), 32'(exp_sad[k]));
    end
    @(posedge clock); #1;
    check("rd_vld_after", 32'(out_valid), 32'd0);
  endtask

  task automatic pass0_basic();
    for (int pix = 0; pix < LINE_PIXELS + 4; pix++) begin
      if (pix == 20) send(1'b1, pix, 0, 70, 60, 80, 90);
      else           send(1'b1, pix, 0, 40, 10, 30, 20);
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_vld",  32'(out_valid),     32'd0);
    check("rst_pix",  32'(out_pixel),     32'd0);
    check("rst_disp", 32'(out_disparity), 32'd0);
    check("rst_sad",  32'(out_sad),       32'd0);
    reset_n = 1'b1;
    idle(2);

    // Row 1: pass 0 plus directed single-pixel updates.
    pass0_basic();
    for (int p = 0; p < LINE_PIXELS; p++) begin
      exp_sad[p]  = 10;
      exp_disp[p] = 1;
    end
    exp_sad[20] = 60;
    idle(2);
    send(1'b1, 5, 42, 7, 50, 50, 50);
    exp_sad[5] = 7; exp_disp[5] = 42;
    idle(2);
    send(1'b1, 7, 8, 9, 9, 9, 9);
    exp_sad[7] = 9; exp_disp[7] = 8;
    idle(2);
    send(1'b1, 5, 60, 7, 8, 8, 8);
    idle(2);
    send(1'b1, 9, 4, 50, 50, 50, 50);
    idle(2);
    send(1'b0, 3, 0, 1, 1, 1, 1);
    send(1'b1, 641, 0, 1, 1, 1, 1);
    idle(6);
    readout(1'b1);

    // Row 2: aborted by reset during pass 7.
    idle(2);
    pass0_basic();
    for (int pix = 0; pix < 300; pix++) send(1'b1, pix, 28, 1, 1, 1, 1);
    valid = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check("arst_vld",  32'(out_valid),     32'd0);
    check("arst_pix",  32'(out_pixel),     32'd0);
    check("arst_disp", 32'(out_disparity), 32'd0);
    check("arst_sad",  32'(out_sad),       32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(2);

    // Row 3: full 16-pass run with a reference minimum per pixel.
    for (int p = 0; p < LINE_PIXELS; p++) begin
      exp_sad[p]  = 1 << 20;
      exp_disp[p] = 0;
      for (int d = 0; d < 64; d++) begin
        if (sadf(p, d) < exp_sad[p]) begin
          exp_sad[p]  = sadf(p, d);
          exp_disp[p] = d;
        end
      end
    end
    for (int ps = 0; ps < 16; ps++) begin
      for (int pix = 0; pix < LINE_PIXELS + 4; pix++) begin
        send(1'b1, pix, 4 * ps, sadf(pix, 4 * ps), sadf(pix, 4 * ps + 1),
             sadf(pix, 4 * ps + 2), sadf(pix, 4 * ps + 3));
      end
    end
    idle(6);
    readout(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/disparity_wta.md
# disparity_wta

Winner-take-all stage that sits directly downstream of the SAD summing pipeline, which is sequenced by `disparity_counter`. Each valid cycle it receives four candidate SADs for one pixel, along with their disparity tags. It keeps a per-pixel best-match (minimum SAD) record for one 640-pixel scanline across the 16 disparity passes. When the clear/readout phase begins, it streams out the winning disparity for each pixel in address order, which forms the depth-map row.

## Interface
Parameters:
- `SAD_W`, default 16: width of each SAD value.
- `SAD_THRESH`, default 16'hFFFF: confidence threshold (used only when `DISPARITY_WTA_THRESH_EN` is defined).

Ports:
- `clock`, in, 1: rising-edge clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `valid`, in, 1: the candidate set on the inputs is live this cycle.
- `pixel`, in, 10: column address of the candidates (0..639).
- `disparity_1`..`disparity_4`, in, 6 each: disparity tags of the four candidates.
- `sad_1`..`sad_4`, in, `SAD_W` each: SAD paired with `disparity_n`.
- `clear_buffer`, in, 1: readout/clear phase, held high for exactly 640 cycles.
- `out_valid`, out, 1: a depth-map pixel is presented.
- `out_pixel`, out, 10: column of the presented pixel.
- `out_disparity`, out, 6: winning disparity.
- `out_sad`, out, `SAD_W`: SAD of the winner.

## Operation
- **Stage 1 (select).** Combinational min over the four (sad, disparity) pairs, then registered.
  - Tie between candidates: the lower-index candidate wins (index 1 beats 2, 2 beats 3, 3 beats 4).
  - Also registered: `s1_valid`, `s1_pixel`, and `s1_first`, where `s1_first = (disparity_1 == 0)`, marking pass 0.
- **Stage 2 (update).** Read-modify-write of buffer entry `best[s1_pixel]`, which holds {sad, disparity}.
  - If `s1_first` is set, the entry is written unconditionally.
  - Otherwise the entry is written only if `s1_sad < best.sad` (strict). On equal SAD the stored, lower-disparity entry is kept.
- **Dropped updates.** A cycle is dropped (no write) when `valid` is 0 or when `pixel > 639`.
- **Readout.**
  - An internal `rd_addr` (10 bits) is 0 while `clear_buffer` is low.
  - While `clear_buffer` is high, `best[rd_addr]` is registered onto the outputs with `out_pixel = rd_addr`, and `rd_addr` increments each cycle.
  - `rd_addr` saturates at 639 and returns to 0 when `clear_buffer` drops.
  - The buffer is not zeroed, because the pass-0 write makes the old contents irrelevant.
- **Priority.** If `valid` and `clear_buffer` are both high in the same cycle, readout wins and the update is dropped.
- **Reset behaviour.**
  - Output registers reset to: `out_valid` = 0, `out_pixel` = 0, `out_disparity` = 0, `out_sad` = 0.
  - Internal registers reset to: `rd_addr` = 0, `s1_valid` = 0.
  - Buffer contents are not reset.
  - Reset during a pass aborts it; the next pass 0 rebuilds every entry.

## Timing
- Candidates are sampled at edge T.
- The stage-1 register is valid after T. The buffer write commits at edge T+1, so the entry is readable from cycle T+2.
- Readout latency is 1 cycle: `clear_buffer` high with `rd_addr = k` at edge T gives `out_valid = 1` and `out_pixel = k` after T.
- `out_valid` stays high for exactly 640 consecutive cycles per row, then 0 from the cycle after `clear_buffer` falls.
- No bypass path exists from stage 2 to readout. The upstream sequencer guarantees at least 5 idle cycles between the last pass-15 write (pixel 639) and the first readout.
- Consecutive valid cycles always address distinct pixels within a pass, so stage 2 has no read-after-write hazard. The 4 blank pixels at each pass boundary (640..643) separate writes to the same pixel.
- Throughput: one candidate set per cycle, with no back-pressure.

## Configuration
- `DISPARITY_WTA_THRESH_EN` defined: at readout, if `best.sad > SAD_THRESH` then `out_disparity` is forced to 0 (invalid/far marker). `out_sad` still reports the true value.
- `DISPARITY_WTA_THRESH_EN` undefined: raw winner output. `SAD_THRESH` is unused, and no comparator is built.

## Structure
- Shared package `disparity_pkg`, containing:
  - constants `LINE_PIXELS = 640`, `DISP_W = 6`, `PIX_W = 10`, `NUM_CAND = 4`;
  - a typedef for the buffer entry struct {sad, disparity}.
- Sub-module `sad_min4`: a purely combinational 4-way minimum with the index-order tie rule. It returns the SAD and disparity of the winner.
- Buffer: 640 × (`SAD_W` + 6) register array or distributed RAM, with a combinational read on the stage-2 address and a registered read on the readout address.

## Test plan
- **Single pass, readout.** Pass 0 only, with `sad_n = {40, 10, 30, 20}` for disparities 0..3 at every pixel, then `clear_buffer` for 640 cycles → 640 outputs, each with disparity 1 and SAD 10, and pixels 0..639 in order.
- **Improvement and strict less-than.** Pixel 5 gets SAD 10 at disparity 1 in pass 0, then SAD 7 at disparity 42 in pass 10 → readout of pixel 5 is disparity 42, SAD 7. A later equal SAD 7 at disparity 60 → still 42.
- **Candidate tie.** `sad_1..4 = {9, 9, 9, 9}` with disparities 8..11 → winner is 8.
- **Blank cycles and collision.** `valid = 0`, or `pixel = 641` with `valid = 1`, leaves entries unchanged. `valid` and `clear_buffer` high together → no write, and readout continues.
- **Reset mid-pass.** Assert `reset_n` low during pass 7 → outputs go to 0 immediately (asynchronously). A fresh 16-pass run afterwards → correct minima with no stale data.
- **Threshold.** With `DISPARITY_WTA_THRESH_EN` and `SAD_THRESH = 50`, a pixel whose best SAD is 60 → `out_disparity` = 0 and `out_sad` = 60. Without the macro → the true winning disparity.
